pipe_hazard_ctrl: RTL

- Central sequencer for the 5-stage RISC-V pipeline: drives enable/flush of PC and the four stage buffer registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Produces EX-stage forwarding selects.
- Detects load-use hazards and taken branches.
- Freezes the pipe on data-memory wait, with a timeout; sequences halt drain to a terminal HALTED state.

---
 rtl/pipe_hazard_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing control for the 5-stage RISC-V pipeline: stage enables/flushes,
// EX forwarding selects, dmem wait freeze with timeout, and halt drain.
module pipe_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_halt,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [WW-1:0] TO_LAST    = WW'(MEM_TIMEOUT - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

  state_t          state_q, state_d;
  state_t          ret_q, ret_d;
  logic [WW-1:0]   wait_q, wait_d, wait_base;
  logic [DW-1:0]   drain_q, drain_d;
  logic            err_d;
  logic            freeze, load_use, timeout_hit, drain_done;
  logic            run_rules, drain_rules;

  // Forwarding: EX/MEM result is younger, so it takes priority over MEM/WB.
  always_comb begin
    fwd_a = 2'b00;
    if (mem_regwrite && mem_rd != '0 && mem_rd == ex_rs1)     fwd_a = 2'b10;
    else if (wb_regwrite && wb_rd != '0 && wb_rd == ex_rs1)   fwd_a = 2'b01;
    fwd_b = 2'b00;
    if (mem_regwrite && mem_rd != '0 && mem_rd == ex_rs2)     fwd_b = 2'b10;
    else if (wb_regwrite && wb_rd != '0 && wb_rd == ex_rs2)   fwd_b = 2'b01;
  end

  assign freeze   = dmem_req && !dmem_ready;
  assign load_use = ex_memread && ex_rd != '0 && (ex_rd == id_rs1 || ex_rd == id_rs2);

  assign wait_base   = (state_q == MEM_WAIT) ? wait_q : '0;
  assign timeout_hit = (MEM_TIMEOUT <= 1) || (wait_base == TO_LAST);
  assign drain_done  = (DRAIN_CYCLES <= 1) || (drain_q == DRAIN_LAST);

  // A MEM_WAIT cycle that completes behaves as the state it interrupted.
  assign run_rules   = (state_q == RUN)   || (state_q == MEM_WAIT && ret_q == RUN);
  assign drain_rules = (state_q == DRAIN) || (state_q == MEM_WAIT && ret_q == DRAIN);

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    state_d     = state_q;
    ret_d       = ret_q;
    wait_d      = wait_q;
    drain_d     = drain_q;
    err_d       = mem_err;

    if (state_q == HALTED) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (freeze) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      if (timeout_hit) begin
        state_d = HALTED;
        err_d   = 1'b1;
        wait_d  = '0;
      end else begin
        state_d = MEM_WAIT;
        wait_d  = wait_base + 1'b1;
        if (state_q != MEM_WAIT) ret_d = state_q;
      end
    end else begin
      wait_d = '0;
      if (run_rules) begin
        state_d = RUN;
        if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else begin
          if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
          if (ex_halt) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = DRAIN;
            drain_d     = '0;
          end
        end
      end else if (drain_rules) begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        state_d     = DRAIN;
        if (drain_done) state_d = HALTED;
        else            drain_d = drain_q + 1'b1;
      end
    end

    if (reset) begin
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      id_ex_en    = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      ret_q        <= RUN;
      wait_q       <= '0;
      drain_q      <= '0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      wait_q  <= wait_d;
      drain_q <= drain_d;
      mem_err <= err_d;
      if (!pc_en && state_q != HALTED && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

  assign halted = (state_q == HALTED);

endmodule
